// File: rtl/fir_coef_loader.sv
// Framed byte-stream loader for the 16-tap FIR coefficient bank: assembles a shadow
// bank, validates format and checksum, commits atomically, then flushes the filter.
module fir_coef_loader #(
  parameter int         FLUSH_CYCLES   = 32,
  parameter int         TIMEOUT_CYCLES = 1000000,
  parameter logic [7:0] HEADER         = 8'hA5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [7:0]   rx_data,
  input  logic         rx_valid,
  output logic [191:0] coef_flat,
  output logic         en_fir_o,
  output logic         load_done_o,
  output logic         load_err_o,
  output logic [1:0]   err_code_o,
  output logic         busy_o
);

  // state   | meaning
  // IDLE    | hunting for HEADER, other bytes ignored
  // PAYLOAD | collecting the 32 payload bytes into the shadow bank
  // CHECK   | waiting for the checksum byte, commit or reject
  // FLUSH   | new bank active, FIR held disabled for FLUSH_CYCLES
  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_PAYLOAD = 2'd1;
  localparam logic [1:0] S_CHECK   = 2'd2;
  localparam logic [1:0] S_FLUSH   = 2'd3;

  localparam logic [1:0] ERR_CSUM = 2'b01;
  localparam logic [1:0] ERR_FMT  = 2'b10;
  localparam logic [1:0] ERR_TMO  = 2'b11;

  localparam int FLW = $clog2(FLUSH_CYCLES + 1);
  localparam int TMW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [FLW-1:0] FLUSH_LOAD = FLW'(FLUSH_CYCLES);
  localparam logic [TMW-1:0] TMR_LOAD   = TMW'(TIMEOUT_CYCLES - 1);

  logic [1:0]     state;
  logic [4:0]     idx;
  logic [7:0]     csum;
  logic           fmt_err;
  logic [TMW-1:0] tmr;
  logic [FLW-1:0] flush_cnt;
  logic [191:0]   shadow;
  logic [7:0]     base;

  assign busy_o = (state != S_IDLE);
  assign base   = 8'(idx[4:1]) * 8'd12;

  // Even bytes carry the high nibble of coef k, odd bytes the low byte.
  always_ff @(posedge clk) begin
    if (state == S_PAYLOAD && rx_valid) begin
      if (idx[0])
        shadow[base +: 8] <= rx_data;
      else
        shadow[base + 8'd8 +: 4] <= rx_data[3:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      idx         <= '0;
      csum        <= '0;
      fmt_err     <= 1'b0;
      tmr         <= '0;
      flush_cnt   <= '0;
      coef_flat   <= '0;
      en_fir_o    <= 1'b0;
      load_done_o <= 1'b0;
      load_err_o  <= 1'b0;
      err_code_o  <= 2'b00;
    end else begin
      load_done_o <= 1'b0;
      load_err_o  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (rx_valid && rx_data == HEADER) begin
            state   <= S_PAYLOAD;
            idx     <= '0;
            csum    <= '0;
            fmt_err <= 1'b0;
            tmr     <= TMR_LOAD;
          end
        end
        S_PAYLOAD: begin
          if (rx_valid) begin
            csum <= csum ^ rx_data;
            if (!idx[0] && rx_data[7:4] != 4'h0)
              fmt_err <= 1'b1;
            idx <= idx + 5'd1;
            tmr <= TMR_LOAD;
            if (idx == 5'd31)
              state <= S_CHECK;
          end else if (tmr == '0) begin
            load_err_o <= 1'b1;
            err_code_o <= ERR_TMO;
            state      <= S_IDLE;
          end else begin
            tmr <= tmr - 1'b1;
          end
        end
        S_CHECK: begin
          if (rx_valid) begin
            if (fmt_err) begin
              load_err_o <= 1'b1;
              err_code_o <= ERR_FMT;
              state      <= S_IDLE;
            end else if (rx_data != csum) begin
              load_err_o <= 1'b1;
              err_code_o <= ERR_CSUM;
              state      <= S_IDLE;
            end else begin
              coef_flat   <= shadow;
              load_done_o <= 1'b1;
              en_fir_o    <= 1'b0;
              flush_cnt   <= FLUSH_LOAD;
              state       <= S_FLUSH;
            end
          end else if (tmr == '0) begin
            load_err_o <= 1'b1;
            err_code_o <= ERR_TMO;
            state      <= S_IDLE;
          end else begin
            tmr <= tmr - 1'b1;
          end
        end
        S_FLUSH: begin
          // Terminal count at 1 so the enable is low for exactly FLUSH_CYCLES cycles.
          flush_cnt <= flush_cnt - 1'b1;
          if (flush_cnt == FLW'(1)) begin
            en_fir_o <= 1'b1;
            state    <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
